// File: rtl/pll_lock_reset_pkg.sv
// Shared definitions for the PLL lock / system reset sequencer.
package pll_lock_reset_pkg;

    localparam int STATE_W = 3;
    localparam int LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABLE    = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLL_RESET = 3'd4
    } state_e;

endpackage

// File: rtl/sync_bit.sv
// Single-bit clock-domain-crossing synchronizer: STAGES flops, async active-low reset to 0.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the asynchronous input one stage further down the chain each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    // Chain registers; bit 0 is the metastability-exposed first stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset.sv
// Reset sequencer downstream of the board PLL: qualifies lock, holds the
// system in reset, re-resets the PLL on a lock timeout and counts run-time lock drops.
module pll_lock_reset
    import pll_lock_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 256,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int PLL_RST_CYCLES = 16,
    parameter int CNT_W          = 21
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               locked,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic [LOSS_W-1:0]  lock_losses,
    output logic [STATE_W-1:0] state
);

    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX     = '1;

    logic                 locked_s;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LOSS_W-1:0]    losses_q, losses_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 sys_rst_n_q, sys_rst_n_d;
    logic                 ready_q, ready_d;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (locked),
        .q       (locked_s)
    );

    // Next-state, shared dwell counter and lock-loss counter.
    always_comb begin
        state_d  = ST_WAIT_LOCK;
        losses_d = losses_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s)                  state_d = ST_STABLE;
                else if (cnt_q == TIMEOUT_LAST) state_d = ST_PLL_RESET;
                else                           state_d = ST_WAIT_LOCK;
            end
            ST_STABLE: begin
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_HOLD;
                else                           state_d = ST_STABLE;
            end
            ST_HOLD: begin
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST)   state_d = ST_RUN;
                else                           state_d = ST_HOLD;
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_WAIT_LOCK;
                    if (losses_q != LOSS_MAX) losses_d = losses_q + LOSS_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PLL_RESET: begin
                // Lock is meaningless while the PLL itself is held in reset.
                if (cnt_q == PLL_RST_LAST)     state_d = ST_PLL_RESET == ST_PLL_RESET ? ST_WAIT_LOCK : ST_WAIT_LOCK;
                else                           state_d = ST_PLL_RESET;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        // Counter restarts on every state change; RUN has no dwell limit so it idles there.
        if (state_d != state_q)     cnt_d = '0;
        else if (state_q == ST_RUN) cnt_d = cnt_q;
        else                        cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        sys_rst_n_d = (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);
        pll_rst_d   = (state_d == ST_PLL_RESET);
    end

    // State, counter and output registers; reset_n clears everything including lock_losses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_LOCK;
            cnt_q       <= '0;
            losses_q    <= '0;
            pll_rst_q   <= 1'b0;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            losses_q    <= losses_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_rst_n   = sys_rst_n_q;
    assign ready       = ready_q;
    assign lock_losses = losses_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pll_lock_reset.sv
// Bench for pll_lock_reset: directed scenarios plus randomized lock activity,
// every cycle compared against an event-level model of the sequencing rules.
module tb_pll_lock_reset;

    localparam int SYNC = 2;
    localparam int S    = 8;
    localparam int H    = 4;
    localparam int T    = 32;
    localparam int P    = 3;
    localparam int QRUN = 1 + S + H;

    logic       clock;
    logic       reset_n;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] lock_losses;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Model: qualification streak, idle (unlocked) time, pending PLL reset cycles, drop count.
    logic m_hist [SYNC];
    int   m_qual;
    int   m_idle;
    int   m_prst;
    int   m_loss;

    pll_lock_reset #(
        .SYNC_STAGES    (SYNC),
        .STABLE_CYCLES  (S),
        .HOLD_CYCLES    (H),
        .TIMEOUT_CYCLES (T),
        .PLL_RST_CYCLES (P),
        .CNT_W          (21)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst_n   (sys_rst_n),
        .ready       (ready),
        .lock_losses (lock_losses),
        .state       (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
        m_qual = 0;
        m_idle = 0;
        m_prst = 0;
        m_loss = 0;
    endtask

    function automatic logic [2:0] exp_state();
        if (m_prst > 0)       return 3'd4;
        if (m_qual == 0)      return 3'd0;
        if (m_qual <= S)      return 3'd1;
        if (m_qual <= S + H)  return 3'd2;
        return 3'd3;
    endfunction

    task automatic model_edge(input logic lk);
        logic ls;
        ls = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = lk;
        if (m_prst > 0) begin
            m_prst--;
            if (m_prst == 0) m_idle = 0;
        end else if (m_qual > 0) begin
            if (ls) begin
                if (m_qual < QRUN) m_qual++;
            end else begin
                if (m_qual >= QRUN && m_loss < 255) m_loss++;
                m_qual = 0;
                m_idle = 0;
            end
        end else begin
            if (ls) m_qual = 1;
            else if (m_idle == T - 1) begin
                m_prst = P;
                m_idle = 0;
            end else m_idle++;
        end
    endtask

    task automatic compare_all();
        chk("sys_rst_n",   8'(sys_rst_n),   8'(m_qual >= QRUN));
        chk("ready",       8'(ready),       8'(m_qual >= QRUN));
        chk("pll_rst",     8'(pll_rst),     8'(m_prst > 0));
        chk("lock_losses", lock_losses,     8'(m_loss));
        chk("state",       8'(state),       8'(exp_state()));
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
    task automatic tick(input logic lk);
        locked = lk;
        @(posedge clock);
        model_edge(lk);
        @(negedge clock);
        compare_all();
    endtask

    // Asynchronous reset between edges; outputs must clear with no clock edge.
    task automatic async_reset_check(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        chk({tag, "_sys_rst_n"}, 8'(sys_rst_n), 8'd0);
        chk({tag, "_ready"},     8'(ready),     8'd0);
        chk({tag, "_pll_rst"},   8'(pll_rst),   8'd0);
        chk({tag, "_losses"},    lock_losses,   8'd0);
        chk({tag, "_state"},     8'(state),     8'd0);
        model_reset();
        @(negedge clock);
        locked  = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        int first;
        int rise1;
        int rise2;
        int highs;
        int n;
        int len;
        logic v;
        logic prev;

        reset_n = 1'b0;
        locked  = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        reset_n = 1'b1;

        // Clean lock.
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1);
            if (first == 0 && sys_rst_n === 1'b1) first = e;
        end
        chk("lockup_edge", 8'(first), 8'd15);

        // Run-time drop and relock.
        first = 0;
        for (int e = 1; e <= 6; e++) begin
            tick(1'b0);
            if (first == 0 && sys_rst_n === 1'b0) first = e;
        end
        chk("drop_edge", 8'(first), 8'd3);
        chk("losses_after_1", lock_losses, 8'd1);
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1);
            if (first == 0 && sys_rst_n === 1'b1) first = e;
        end
        chk("relock_edge", 8'(first), 8'd15);

        // Drive the drop counter into saturation.
        for (int d = 2; d <= 300; d++) begin
            repeat ($urandom_range(1, 3)) tick(1'b0);
            repeat (15 + $urandom_range(0, 2)) tick(1'b1);
        end
        chk("losses_sat", lock_losses, 8'd255);

        // Reach HOLD and reset asynchronously there.
        repeat (2) tick(1'b0);
        for (int i = 0; i < 40 && exp_state() != 3'd2; i++) tick(1'b1);
        chk("state_in_hold", 8'(state), 8'd2);
        async_reset_check("rst_hold");

        // Flaky lock: high 5, low 1, then high.
        repeat (5) tick(1'b1);
        tick(1'b0);
        first = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(1'b1);
            if (first == 0 && sys_rst_n === 1'b1) first = e;
        end
        chk("flaky_edge", 8'(first), 8'd15);
        chk("flaky_losses", lock_losses, 8'd0);

        // Randomized lock activity.
        n = 0;
        while (n < 600) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 24);
            repeat (len) tick(v);
            n += len;
        end

        // No lock: periodic PLL reset pulses, then reset while the pulse is high.
        async_reset_check("rst_pre_nolock");
        rise1 = 0;
        rise2 = 0;
        highs = 0;
        prev  = 1'b0;
        for (int e = 1; e <= 68; e++) begin
            tick(1'b0);
            if (pll_rst === 1'b1) begin
                highs++;
                if (!prev) begin
                    if (rise1 == 0) rise1 = e;
                    else if (rise2 == 0) rise2 = e;
                end
            end
            prev = pll_rst;
        end
        chk("pll_rst_rise1", 8'(rise1), 8'd32);
        chk("pll_rst_rise2", 8'(rise2), 8'd67);
        chk("pll_rst_highs", 8'(highs), 8'd5);
        chk("pll_rst_before_rst", 8'(pll_rst), 8'd1);
        async_reset_check("rst_pllreset");

        // Illegal state encoding recovers to WAIT_LOCK.
        locked = 1'b0;
        force dut.state_q = 3'd6;
        @(posedge clock);
        #1;
        release dut.state_q;
        @(posedge clock);
        #1;
        chk("illegal_recover", 8'(state), 8'd0);
        chk("illegal_pll_rst", 8'(pll_rst), 8'd0);
        chk("illegal_sys_rst_n", 8'(sys_rst_n), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
